// File: rtl/cpu_mul_pkg.sv
// Shared constants and stage payload types for the multiplier combine pipeline.
// CPU_MUL_COMBINE_HI_EN widens the stage payloads to carry the hi·hi product and high word.
package cpu_mul_pkg;

    localparam int MUL_DATA_W = 32;
    localparam int MUL_HALF_W = MUL_DATA_W / 2;

`ifdef CPU_MUL_COMBINE_HI_EN
    localparam int MUL_MID_W = MUL_DATA_W + 1;
`else
    localparam int MUL_MID_W = MUL_HALF_W;
`endif

    typedef struct packed {
        logic [MUL_MID_W-1:0]  mid;
        logic [MUL_DATA_W-1:0] p1;
`ifdef CPU_MUL_COMBINE_HI_EN
        logic [MUL_DATA_W-1:0] p4;
`endif
    } stage_a_t;

    typedef struct packed {
        logic [MUL_DATA_W-1:0] lo;
`ifdef CPU_MUL_COMBINE_HI_EN
        logic [MUL_DATA_W-1:0] hi;
`endif
    } stage_b_t;

endpackage

// File: rtl/cpu_mul_pipe_reg.sv
// Generic valid/ready register slice with synchronous flush; payload is opaque.
// Holds at most one entry and can drain and reload in the same cycle.
module cpu_mul_pipe_reg #(
    parameter int PAYLOAD_W = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush,
    input  logic                 up_valid,
    output logic                 up_ready,
    input  logic [PAYLOAD_W-1:0] up_data,
    output logic                 dn_valid,
    input  logic                 dn_ready,
    output logic [PAYLOAD_W-1:0] dn_data
);

    logic                 vld_q;
    logic [PAYLOAD_W-1:0] data_q;
    logic                 load;

    assign up_ready = (!vld_q || dn_ready) && !flush;
    assign load     = up_valid && up_ready;
    assign dn_valid = vld_q;
    assign dn_data  = data_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q <= 1'b0;
        end else if (flush) begin
            vld_q <= 1'b0;
        end else if (load) begin
            vld_q <= 1'b1;
        end else if (dn_ready) begin
            vld_q <= 1'b0;
        end
    end

    // Data is only captured on a load so the output stays stable under backpressure.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_q <= '0;
        end else if (load) begin
            data_q <= up_data;
        end
    end

endmodule

// File: rtl/cpu_mul_combine.sv
// Reduces 16x16 partial products to the 32x32 product word(s) in two pipeline stages.
// CPU_MUL_COMBINE_HI_EN adds the hi·hi input and the high result word.
module cpu_mul_combine
    import cpu_mul_pkg::*;
#(
    parameter int DATA_W = MUL_DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] M_mul_cell_p1,
    input  logic [DATA_W-1:0] M_mul_cell_p2,
    input  logic [DATA_W-1:0] M_mul_cell_p3,
`ifdef CPU_MUL_COMBINE_HI_EN
    input  logic [DATA_W-1:0] M_mul_cell_p4,
`endif
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] W_mul_result
`ifdef CPU_MUL_COMBINE_HI_EN
    ,
    output logic [DATA_W-1:0] W_mul_result_hi
`endif
);

    stage_a_t a_in, a_p0;
    stage_b_t b_in, b_p1;
    logic     vld_p0, vld_p1;
    logic     b_ready;

    function automatic stage_b_t combine(input stage_a_t a);
        stage_b_t r;
`ifdef CPU_MUL_COMBINE_HI_EN
        logic [2*MUL_DATA_W-1:0] full;
        full = {a.p4, a.p1} + ({{(MUL_DATA_W-1){1'b0}}, a.mid} << MUL_HALF_W);
        r.lo = full[MUL_DATA_W-1:0];
        r.hi = full[2*MUL_DATA_W-1:MUL_DATA_W];
`else
        r.lo = a.p1 + {a.mid, {MUL_HALF_W{1'b0}}};
`endif
        return r;
    endfunction

    // Stage A input: cross terms summed, carry kept only when the high word is needed
`ifdef CPU_MUL_COMBINE_HI_EN
    assign a_in.mid = {1'b0, M_mul_cell_p2} + {1'b0, M_mul_cell_p3};
    assign a_in.p4  = M_mul_cell_p4;
`else
    assign a_in.mid = MUL_MID_W'(M_mul_cell_p2 + M_mul_cell_p3);
`endif
    assign a_in.p1  = M_mul_cell_p1;

    cpu_mul_pipe_reg #(
        .PAYLOAD_W($bits(stage_a_t))
    ) u_stage_a (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (flush),
        .up_valid (in_valid),
        .up_ready (in_ready),
        .up_data  (a_in),
        .dn_valid (vld_p0),
        .dn_ready (b_ready),
        .dn_data  (a_p0)
    );

    // Stage B input: final shifted add
    assign b_in = combine(a_p0);

    cpu_mul_pipe_reg #(
        .PAYLOAD_W($bits(stage_b_t))
    ) u_stage_b (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (flush),
        .up_valid (vld_p0),
        .up_ready (b_ready),
        .up_data  (b_in),
        .dn_valid (vld_p1),
        .dn_ready (out_ready),
        .dn_data  (b_p1)
    );

    assign out_valid    = vld_p1;
    assign W_mul_result = b_p1.lo;
`ifdef CPU_MUL_COMBINE_HI_EN
    assign W_mul_result_hi = b_p1.hi;
`endif

endmodule
